axi4_mem_port_arbiter: RTL and testbench

Shares the single-port synchronous AXI4 slave memory between the write-channel and read-channel datapaths. Each requester presents beats over a req/gnt handshake. The block drives the memory enable/write/address/data port from the granted side. Ownership is locked per burst, with a round-robin tie-break and a cycle-count preemption limit, and the block returns read data with fixed latency.

---
 rtl/axi4_mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_axi4_mem_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between a write requester and a read requester.
// Ownership is locked per burst, with round-robin tie-break, hold-limit preemption and fixed-latency read return.
module axi4_mem_port_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int MAX_HOLD       = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      wr_req,
   input  logic                      wr_last,
   input  logic [MEM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      wr_gnt,
   input  logic                      rd_req,
   input  logic                      rd_last,
   input  logic [MEM_ADDR_WIDTH-1:0] rd_addr,
   output logic                      rd_gnt,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_data_valid,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy
);

   // state  | meaning
   // IDLE   | nobody owns the memory port
   // WR_OWN | write side owns the port until its last beat or preemption
   // RD_OWN | read side owns the port until its last beat or preemption
   typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN} state_t;

   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

   state_t                    state_q, state_d;
   logic [HW-1:0]             hold_q, hold_d;
   logic                      last_rd_q, last_rd_d;
   logic                      mem_en_q, mem_en_d;
   logic                      mem_we_q, mem_we_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
   logic                      rd_pend_q, rd_vld_q;

   logic wr_acc, rd_acc, hold_full;

   assign wr_acc    = (state_q == WR_OWN) && wr_req;
   assign rd_acc    = (state_q == RD_OWN) && rd_req;
   assign hold_full = (hold_q == HOLD_MAX);

   always_comb begin
      state_d   = state_q;
      last_rd_d = last_rd_q;
      case (state_q)
         IDLE: begin
            if (wr_req && rd_req)
               state_d = last_rd_q ? WR_OWN : RD_OWN;
            else if (wr_req)
               state_d = WR_OWN;
            else if (rd_req)
               state_d = RD_OWN;
         end
         WR_OWN: begin
            if ((wr_acc && wr_last) || (hold_full && rd_req)) begin
               state_d   = rd_req ? RD_OWN : IDLE;
               last_rd_d = 1'b0;
            end
         end
         RD_OWN: begin
            if ((rd_acc && rd_last) || (hold_full && wr_req)) begin
               state_d   = wr_req ? WR_OWN : IDLE;
               last_rd_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q)
         hold_d = '0;
      else if (state_q != IDLE && !hold_full)
         hold_d = hold_q + HW'(1);
      else
         hold_d = hold_q;
   end

   // Memory port is registered from whichever side had a beat accepted this cycle.
   always_comb begin
      mem_en_d    = wr_acc | rd_acc;
      mem_we_d    = wr_acc;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (wr_acc) begin
         mem_addr_d  = wr_addr;
         mem_wdata_d = wr_data;
      end else if (rd_acc) begin
         mem_addr_d  = rd_addr;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         last_rd_q   <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         last_rd_q   <= last_rd_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_pend_q   <= rd_acc;
         rd_vld_q    <= rd_pend_q;
      end
   end

   assign wr_gnt        = (state_q == WR_OWN);
   assign rd_gnt        = (state_q == RD_OWN);
   assign mem_en        = mem_en_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign rd_data_valid = rd_vld_q;
   assign rd_data       = mem_rdata;
   assign busy          = (state_q != IDLE) || rd_pend_q || rd_vld_q;

endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// Random-burst bench for axi4_mem_port_arbiter: behavioural ownership model plus scoreboard queues
// for memory-port transactions and returned read data.
module tb_axi4_mem_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int MH = 4;
   localparam int NCYC = 6000;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          wr_req, wr_last, rd_req, rd_last;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic          wr_gnt, rd_gnt, rd_data_valid, mem_en, mem_we, busy;
   logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always #5 ACLK = ~ACLK;

   axi4_mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .wr_req(wr_req), .wr_last(wr_last), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_last(rd_last), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Simulated memory slave: one-cycle read latency.
   logic [DW-1:0] mem_arr [0:1023];
   always @(posedge ACLK) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   // Reference model: owner 0=none 1=write 2=read; owned = cycles held in the current tenure.
   typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_t;
   mem_t          memq [$];
   logic [DW-1:0] rdq  [$];
   logic [DW-1:0] ref_mem [0:1023];
   int            owner, owned, last_side;
   bit            acc_wr_ev, acc_rd_ev, st1, rdv, exp_en, exp_we;
   bit            other_req, mine_last;
   logic [DW-1:0] exp_wdata;
   bit            started = 0;
   int            vectors = 0, miscompares = 0;

   always @(posedge ACLK) begin
      if (ARESET) begin
         owner = 0; owned = 0; last_side = 2;
         st1 = 0; rdv = 0; exp_en = 0; exp_we = 0; exp_wdata = '0;
         acc_wr_ev = 0; acc_rd_ev = 0;
         memq.delete(); rdq.delete();
      end else begin
         acc_wr_ev = (owner == 1) && wr_req;
         acc_rd_ev = (owner == 2) && rd_req;
         rdv = st1;
         st1 = acc_rd_ev;
         exp_en = acc_wr_ev || acc_rd_ev;
         exp_we = acc_wr_ev;
         if (acc_wr_ev) begin
            ref_mem[wr_addr] = wr_data;
            exp_wdata = wr_data;
            memq.push_back('{1'b1, wr_addr, wr_data});
         end
         if (acc_rd_ev) begin
            rdq.push_back(ref_mem[rd_addr]);
            memq.push_back('{1'b0, rd_addr, exp_wdata});
         end
         if (owner == 0) begin
            if (wr_req && rd_req) owner = (last_side == 2) ? 1 : 2;
            else if (wr_req)      owner = 1;
            else if (rd_req)      owner = 2;
            owned = (owner != 0) ? 1 : 0;
         end else begin
            other_req = (owner == 1) ? rd_req : wr_req;
            mine_last = (owner == 1) ? (acc_wr_ev && wr_last) : (acc_rd_ev && rd_last);
            if (mine_last || (owned >= MH && other_req)) begin
               last_side = owner;
               owner = other_req ? 3 - owner : 0;
               owned = other_req ? 1 : 0;
            end else begin
               owned++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: sample away from the active edge.
   always @(negedge ACLK) begin
      if (started) begin
         mem_t m;
         chk("wr_gnt", 32'(wr_gnt), 32'(owner == 1));
         chk("rd_gnt", 32'(rd_gnt), 32'(owner == 2));
         chk("mem_en", 32'(mem_en), 32'(exp_en));
         chk("mem_we", 32'(mem_we), 32'(exp_we));
         chk("busy", 32'(busy), 32'((owner != 0) || st1 || rdv));
         chk("rd_data_valid", 32'(rd_data_valid), 32'(rdv));
         if (mem_en) begin
            if (memq.size() == 0) begin
               chk("mem_txn_expected", 32'(memq.size()), 32'd1);
            end else begin
               m = memq.pop_front();
               chk("mem_addr", 32'(mem_addr), 32'(m.addr));
               chk("mem_wdata", mem_wdata, m.data);
            end
         end
         if (rd_data_valid) begin
            if (rdq.size() == 0) chk("rd_expected", 32'(rdq.size()), 32'd1);
            else                 chk("rd_data", rd_data, rdq.pop_front());
         end
      end
   end

   int wl, rl;
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      ARESET = 1'b1;
      wr_req = 0; wr_last = 0; wr_addr = '0; wr_data = '0;
      rd_req = 0; rd_last = 0; rd_addr = '0;
      wl = 0; rl = 0;
      repeat (3) @(posedge ACLK);
      #1 started = 1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc > 0) begin
            @(posedge ACLK);
            #1;
         end
         if (ARESET) begin
            ARESET = 1'b0;
            wl = 0; rl = 0;
         end else begin
            if (acc_wr_ev) begin wl--; wr_addr = wr_addr + 1'b1; wr_data = $urandom; end
            if (acc_rd_ev) begin rl--; rd_addr = rd_addr + 1'b1; end
         end
         if (wl == 0 && $urandom_range(0, 2) == 0) begin
            wl = $urandom_range(1, 7); wr_addr = AW'($urandom_range(0, 15)); wr_data = $urandom;
         end
         if (rl == 0 && $urandom_range(0, 2) == 0) begin
            rl = $urandom_range(1, 7); rd_addr = AW'($urandom_range(0, 15));
         end
         wr_req  = (wl > 0) && ($urandom_range(0, 4) != 0);
         wr_last = (wl == 1);
         rd_req  = (rl > 0) && ($urandom_range(0, 4) != 0);
         rd_last = (rl == 1);
         if ((acc_rd_ev && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0)
            ARESET = 1'b1;
      end
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      wr_req = 0; rd_req = 0;
      repeat (8) @(posedge ACLK);
      #1;
      chk("memq_drained", 32'(memq.size()), 32'd0);
      chk("rdq_drained", 32'(rdq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
